// File: rtl/conv1_maxpool_pkg.sv
// -----------------------------------------------------------------------------
// conv1_maxpool_pkg
// Shared CNN geometry and width constants for the pooling stage that follows
// conv1. The 5x5 convolution over a 28x28 image leaves 24x24 valid samples.
// Pool layer 1 keeps the conv1 sample width by default.
// Also provides a small helper that sizes counters and addresses.
// -----------------------------------------------------------------------------
package conv1_maxpool_pkg;

    localparam int CNN_CONV1_OUT_ROWS = 24;
    localparam int CNN_CONV1_OUT_COLS = 24;
    localparam int CNN_CONV1_OUT_W    = 32;
    localparam int CNN_POOL1_OUT_W    = 32;

    // Index width needed to address 'depth' entries. Never returns less than
    // one bit, so that a depth of 1 still gives a legal vector.
    function automatic int idx_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/conv1_maxpool_rowbuf.sv
// -----------------------------------------------------------------------------
// pool_rowbuf
// Holds one row of horizontal maxima for the 2x2 pooling window. Writes are
// synchronous and reads are combinational. One address serves both the write
// and the read, because a given cycle only writes (even row) or only reads
// (odd row).
//
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   wr_en       write strobe
//   addr        entry index (pooled column)
//   wr_data     horizontal max from the even row
//   rd_data     stored horizontal max for 'addr'
// -----------------------------------------------------------------------------
module pool_rowbuf #(
    parameter int DEPTH = 12,
    parameter int W     = 32,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [AW-1:0] addr,
    input  logic [W-1:0]  wr_data,
    output logic [W-1:0]  rd_data
);

    logic [W-1:0] mem [DEPTH];

    // NOTE: this storage array is reset only because a zeroed power-up state
    // is part of the block's defined behaviour. A plain buffer whose entries
    // are always written before they are read would normally skip the reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[addr] <= wr_data;
        end
    end

    assign rd_data = mem[addr];

endmodule

// File: rtl/conv1_maxpool.sv
// -----------------------------------------------------------------------------
// conv1_maxpool
// Streaming 2x2, stride-2 max pooling of the conv1 output stream. A sample is
// accepted when pool_data_in_valid and img_in_en are both high. The position
// is tracked in raster order.
//   - Even columns load a hold register.
//   - Odd columns form the horizontal max.
//   - On even rows, that max goes into the row buffer.
//   - On odd rows, it is combined with the stored value and registered out.
//
// Ports:
//   clk, rst_n           clock and asynchronous active-low reset
//   img_in_en            frame enable; low returns the position to (0,0)
//   pool_data_in         conv1 sample (unsigned, MSB always 0)
//   pool_data_in_valid   sample qualifier, gaps allowed
//   pool_data_out        pooled sample, held until the next output
//   pool_data_out_valid  one-cycle qualifier per pooled sample
//   frame_done           pulses with the last pooled sample of a frame
//
// Build option:
//   POOL_SAT_EN  when defined, pooled values that exceed OUT_W bits saturate
//                to all ones. Otherwise the upper bits are truncated.
// -----------------------------------------------------------------------------
module conv1_maxpool
    import conv1_maxpool_pkg::*;
#(
    parameter int IN_W  = CNN_CONV1_OUT_W,
    parameter int OUT_W = CNN_POOL1_OUT_W,
    parameter int IMG_W = CNN_CONV1_OUT_COLS,
    parameter int IMG_H = CNN_CONV1_OUT_ROWS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             img_in_en,
    input  logic [IN_W-1:0]  pool_data_in,
    input  logic             pool_data_in_valid,
    output logic [OUT_W-1:0] pool_data_out,
    output logic             pool_data_out_valid,
    output logic             frame_done
);

    localparam int COL_W = idx_w(IMG_W);
    localparam int ROW_W = idx_w(IMG_H);
    localparam int AW    = idx_w(IMG_W / 2);

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic [IN_W-1:0]  h;
    logic [IN_W-1:0]  hmax;
    logic [IN_W-1:0]  rb_rd;
    logic [IN_W-1:0]  pmax;
    logic [OUT_W-1:0] out_next;
    logic [AW-1:0]    rb_addr;
    logic             accept;
    logic             last_col;
    logic             last_row;
    logic             rb_wr;
    logic             emit;

    assign accept   = pool_data_in_valid & img_in_en;
    assign last_col = (col == COL_LAST);
    assign last_row = (row == ROW_LAST);

    // Samples are non-negative, so a plain unsigned compare gives the max.
    assign hmax = (pool_data_in > h) ? pool_data_in : h;
    assign pmax = (rb_rd > hmax) ? rb_rd : hmax;

    // Bit 0 of each counter tells whether the position is odd.
    assign rb_addr = AW'(col >> 1);
    assign rb_wr   = accept & ~row[0] & col[0];
    assign emit    = accept & row[0] & col[0];

    pool_rowbuf #(
        .DEPTH (IMG_W / 2),
        .W     (IN_W),
        .AW    (AW)
    ) u_rowbuf (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (rb_wr),
        .addr    (rb_addr),
        .wr_data (hmax),
        .rd_data (rb_rd)
    );

    // NOTE: sequential state uses non-blocking assignments. Every flop then
    // samples the pre-edge values, whatever order the blocks are evaluated in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col <= '0;
            row <= '0;
            h   <= '0;
        end else if (!img_in_en) begin
            // An aborted frame restarts cleanly at (0,0). Stale row buffer
            // entries are rewritten by the even row before they are read.
            col <= '0;
            row <= '0;
            h   <= '0;
        end else if (pool_data_in_valid) begin
            if (!col[0]) begin
                h <= pool_data_in;
            end
            if (last_col) begin
                col <= '0;
                row <= last_row ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

`ifdef POOL_SAT_EN
    localparam logic [IN_W-1:0] OUT_MAX = IN_W'({OUT_W{1'b1}});
`endif

    // NOTE: the default assignment comes first, so every path through this
    // always_comb assigns out_next and no latch is inferred.
    always_comb begin
        out_next = pmax[OUT_W-1:0];
`ifdef POOL_SAT_EN
        if (pmax > OUT_MAX) begin
            out_next = '1;
        end
`endif
    end

    // Output register. The data holds between outputs; valid and frame_done
    // are single-cycle strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pool_data_out       <= '0;
            pool_data_out_valid <= 1'b0;
            frame_done          <= 1'b0;
        end else begin
            pool_data_out_valid <= emit;
            frame_done          <= emit & last_row & last_col;
            if (emit) begin
                pool_data_out <= out_next;
            end
        end
    end

endmodule
